// File: rtl/sopc_run_ctrl_if.sv
// ----------------------------------------------------------------------------
// sopc_run_ctrl_if
//   Control/status bundle between the run supervisor and whoever drives it
//   (a testbench or a host).
//
//   Parameters
//     NUM_DOMAINS  number of downstream reset domains
//     CNT_W        width of cycle_count
//
//   Signals
//     start        start request (to supervisor)
//     abort        return-to-idle request (to supervisor)
//     halt_req     halt request from the cores (to supervisor)
//     domain_rst   per-domain reset, active-high (from supervisor)
//     running      1 while in RUN (from supervisor)
//     done         sticky run-completed flag (from supervisor)
//     timeout      sticky cycle-budget-exhausted flag (from supervisor)
//     state        encoded FSM state (from supervisor)
//     cycle_count  RUN cycles elapsed (from supervisor)
//
//   Modports
//     master       the controlling side (drives the requests)
//     slave        the supervisor itself (drives the status)
// ----------------------------------------------------------------------------
interface sopc_run_ctrl_if #(
    parameter int NUM_DOMAINS = 2,
    parameter int CNT_W       = 32
);
    logic                   start;
    logic                   abort;
    logic                   halt_req;
    logic [NUM_DOMAINS-1:0] domain_rst;
    logic                   running;
    logic                   done;
    logic                   timeout;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cycle_count;

    modport master (
        output start, abort, halt_req,
        input  domain_rst, running, done, timeout, state, cycle_count
    );

    modport slave (
        input  start, abort, halt_req,
        output domain_rst, running, done, timeout, state, cycle_count
    );
endinterface

// File: rtl/sopc_run_ctrl.sv
// ----------------------------------------------------------------------------
// sopc_run_ctrl
//   Reset sequencer and run supervisor for the min-SOPC and its multi-core
//   variants. Holds all downstream reset domains asserted, releases them in
//   a staggered order after a start request, counts run cycles and ends the
//   run on a halt request (DONE) or when the cycle budget is used up
//   (TIMEOUT). When a run ends all domains go back into reset and the status
//   is frozen until the next start or an abort.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous, active-low reset
//     bus    control/status bundle (slave side), see sopc_run_ctrl_if
//
//   Every output is taken straight from a flop; no input reaches an output
//   without passing through a clock edge.
// ----------------------------------------------------------------------------
module sopc_run_ctrl #(
    parameter int NUM_DOMAINS     = 2,
    parameter int RST_HOLD_CYCLES = 10,
    parameter int STAGGER_CYCLES  = 4,
    parameter int MAX_RUN_CYCLES  = 100,
    parameter int CNT_W           = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    sopc_run_ctrl_if.slave bus
);

    localparam int PH_W = $clog2(RST_HOLD_CYCLES + NUM_DOMAINS * STAGGER_CYCLES + 1);

    // Phase value seen in the cycle before the edge that releases the last
    // domain; that same edge also enters RUN.
    localparam int LAST_AT = RST_HOLD_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES - 1;

    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

    // Parameter sanity checks, reported during elaboration.
    if (NUM_DOMAINS < 1) begin : g_chk_domains
        $error("sopc_run_ctrl: NUM_DOMAINS must be >= 1");
    end
    if (RST_HOLD_CYCLES < 1) begin : g_chk_hold
        $error("sopc_run_ctrl: RST_HOLD_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 0) begin : g_chk_stagger
        $error("sopc_run_ctrl: STAGGER_CYCLES must be >= 0");
    end
    if ((MAX_RUN_CYCLES < 1) ||
        ((CNT_W < 63) && (longint'(MAX_RUN_CYCLES) > ((64'sd1 <<< CNT_W) - 64'sd1)))) begin : g_chk_budget
        $error("sopc_run_ctrl: MAX_RUN_CYCLES must be in 1 .. 2^CNT_W-1");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    state_t                 state_q,      state_d;
    logic [PH_W-1:0]        phase_q,      phase_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   running_q,    running_d;
    logic                   done_q,       done_d;
    logic                   timeout_q,    timeout_d;
    logic [CNT_W-1:0]       count_q,      count_d;

    // Zero-extended phase so it can be compared against integer release times.
    logic [31:0] phase_ext;
    assign phase_ext = 32'(phase_q);

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            domain_rst_q <= {NUM_DOMAINS{1'b1}};
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            domain_rst_q <= domain_rst_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    // Next-state and next-output logic. Abort overrides everything,
    // including a simultaneous start.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        domain_rst_d = domain_rst_q;
        running_d    = running_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        count_d      = count_q;

        if (bus.abort) begin
            state_d      = ST_IDLE;
            phase_d      = '0;
            domain_rst_d = {NUM_DOMAINS{1'b1}};
            running_d    = 1'b0;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
            count_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    domain_rst_d = {NUM_DOMAINS{1'b1}};
                    if (bus.start) begin
                        state_d = ST_HOLD;
                        phase_d = '0;
                    end
                end

                // HOLD and RELEASE share one phase counter that keeps running
                // from the start edge; domain i drops on the edge where the
                // phase reaches its release time. With zero stagger every
                // domain matches on the same edge and RELEASE is skipped.
                ST_HOLD, ST_RELEASE: begin
                    phase_d = phase_q + 1'b1;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (phase_ext == 32'(RST_HOLD_CYCLES + i * STAGGER_CYCLES - 1)) begin
                            domain_rst_d[i] = 1'b0;
                        end
                    end
                    if (phase_ext == 32'(LAST_AT)) begin
                        state_d   = ST_RUN;
                        running_d = 1'b1;
                        count_d   = '0;
                    end else if ((state_q == ST_HOLD) &&
                                 (phase_ext == 32'(RST_HOLD_CYCLES - 1))) begin
                        state_d = ST_RELEASE;
                    end
                end

                // The edge that leaves RUN still counts as a run cycle, so
                // the count always advances here. A halt in the last budget
                // cycle is reported as DONE rather than TIMEOUT.
                ST_RUN: begin
                    count_d = count_q + 1'b1;
                    if (bus.halt_req) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        running_d    = 1'b0;
                        domain_rst_d = {NUM_DOMAINS{1'b1}};
                    end else if (count_q == BUDGET_LAST) begin
                        state_d      = ST_TIMEOUT;
                        timeout_d    = 1'b1;
                        running_d    = 1'b0;
                        domain_rst_d = {NUM_DOMAINS{1'b1}};
                    end
                end

                ST_DONE, ST_TIMEOUT: begin
                    domain_rst_d = {NUM_DOMAINS{1'b1}};
                    if (bus.start) begin
                        state_d   = ST_HOLD;
                        phase_d   = '0;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        count_d   = '0;
                    end
                end

                default: begin
                    state_d      = ST_IDLE;
                    phase_d      = '0;
                    domain_rst_d = {NUM_DOMAINS{1'b1}};
                    running_d    = 1'b0;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    count_d      = '0;
                end
            endcase
        end
    end

    assign bus.domain_rst  = domain_rst_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.state       = state_q;
    assign bus.cycle_count = count_q;

endmodule
